// File: rtl/lsu_data_master_pkg.sv
// Shared types for the LSU data master: access size encodings and latched-op record.
package lsu_data_master_pkg;

  localparam int LSU_SIZE_BITS = 2;

  typedef enum logic [LSU_SIZE_BITS-1:0] {
    LSU_SIZE_B = 2'b00,
    LSU_SIZE_H = 2'b01,
    LSU_SIZE_W = 2'b10,
    LSU_SIZE_X = 2'b11
  } lsu_size_e;

  typedef struct packed {
    logic      we;
    lsu_size_e size;
    logic      uns;
    logic [1:0] off;
  } lsu_op_t;

endpackage

// File: rtl/lsu_data_master_align.sv
// Byte-lane steering: store be/wdata replication, load shift/extend, misalignment detect.
module lsu_data_master_align
  import lsu_data_master_pkg::*;
(
  input  lsu_size_e   st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  output logic        misaligned,
  input  lsu_size_e   ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    st_be        = 4'b0000;
    st_wdata_rep = st_wdata;
    misaligned   = 1'b0;
    case (st_size)
      LSU_SIZE_B: begin
        st_be        = 4'b0001 << st_off;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      LSU_SIZE_H: begin
        st_be        = 4'b0011 << st_off;
        st_wdata_rep = {2{st_wdata[15:0]}};
        misaligned   = st_off[0];
      end
      LSU_SIZE_W: begin
        st_be      = 4'b1111;
        misaligned = |st_off;
      end
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    shifted = ld_rdata >> {ld_off, 3'b000};
    ld_data = shifted;
    case (ld_size)
      LSU_SIZE_B: ld_data = {{24{shifted[7] & ~ld_unsigned}}, shifted[7:0]};
      LSU_SIZE_H: ld_data = {{16{shifted[15] & ~ld_unsigned}}, shifted[15:0]};
      default:    ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_data_master.sv
// Load/store initiator: one bus transaction per op on a req/gnt/rvalid port, with a
// watchdog that aborts a stalled grant or response.
module lsu_data_master
  import lsu_data_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 15,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic                  op_we_i,
  input  logic [1:0]            op_size_i,
  input  logic                  op_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] op_addr_i,
  input  logic [DATA_WIDTH-1:0] op_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic                  data_req_o,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic [DATA_WIDTH-1:0] data_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ERR} state_e;

  localparam logic [7:0] TMAX = 8'(TIMEOUT_CYCLES - 1);

  state_e      state;
  lsu_op_t     lat;
  logic [7:0]  tcnt;
  logic [3:0]  st_be;
  logic [31:0] st_wdata_rep;
  logic [31:0] ld_data;
  logic        misaligned;

  lsu_data_master_align u_align (
    .st_size     (lsu_size_e'(op_size_i)),
    .st_off      (op_addr_i[1:0]),
    .st_wdata    (op_wdata_i),
    .st_be       (st_be),
    .st_wdata_rep(st_wdata_rep),
    .misaligned  (misaligned),
    .ld_size     (lat.size),
    .ld_off      (lat.off),
    .ld_unsigned (lat.uns),
    .ld_rdata    (data_rdata_i),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      lat          <= '0;
      tcnt         <= '0;
      op_ready_o   <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= '0;
      rsp_err_o    <= 1'b0;
      busy_o       <= 1'b0;
      data_req_o   <= 1'b0;
      data_addr_o  <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_wdata_o <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      case (state)
        S_IDLE: begin
          op_ready_o <= 1'b1;
          if (op_valid_i && op_ready_o) begin
            op_ready_o <= 1'b0;
            if (misaligned) begin
              state <= S_ERR;
            end else begin
              lat          <= '{we: op_we_i, size: lsu_size_e'(op_size_i),
                                uns: op_unsigned_i, off: op_addr_i[1:0]};
              data_addr_o  <= {op_addr_i[ADDR_WIDTH-1:2], 2'b00};
              data_we_o    <= op_we_i;
              data_be_o    <= st_be;
              data_wdata_o <= st_wdata_rep;
              data_req_o   <= 1'b1;
              busy_o       <= 1'b1;
              tcnt         <= '0;
              state        <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            tcnt       <= '0;
            state      <= S_WAIT;
          end else if (tcnt == TMAX) begin
            data_req_o  <= 1'b0;
            busy_o      <= 1'b0;
            op_ready_o  <= 1'b1;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            state       <= S_IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (data_rvalid_i) begin
            busy_o      <= 1'b0;
            op_ready_o  <= 1'b1;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= lat.we ? '0 : ld_data;
            state       <= S_IDLE;
          end else if (tcnt == TMAX) begin
            busy_o      <= 1'b0;
            op_ready_o  <= 1'b1;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            state       <= S_IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_ERR: begin
          op_ready_o  <= 1'b1;
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_data_master.sv
// Scoreboard bench for lsu_data_master: expected responses queued at issue, checked on rsp_valid.
module tb_lsu_data_master;

  localparam int AW  = 15;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid, op_ready, op_we, op_unsigned;
  logic [1:0]    op_size;
  logic [AW-1:0] op_addr;
  logic [31:0]   op_wdata;
  logic          rsp_valid, rsp_err, busy;
  logic [31:0]   rsp_rdata;
  logic          data_req, data_we, data_gnt, data_rvalid;
  logic [AW-1:0] data_addr;
  logic [3:0]    data_be;
  logic [31:0]   data_wdata, data_rdata;

  int total = 0;
  int bad   = 0;
  logic [32:0] sb[$];

  lsu_data_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .op_valid_i(op_valid), .op_ready_o(op_ready), .op_we_i(op_we),
    .op_size_i(op_size), .op_unsigned_i(op_unsigned), .op_addr_i(op_addr),
    .op_wdata_i(op_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .busy_o(busy),
    .data_req_o(data_req), .data_addr_o(data_addr), .data_we_o(data_we),
    .data_be_o(data_be), .data_wdata_o(data_wdata),
    .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata)
  );

  always #5 clk = ~clk;

  // Response monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got err=%0b rdata=%h, none expected", rsp_err, rsp_rdata);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        if ({rsp_err, rsp_rdata} !== e) begin
          bad++;
          $display("FAIL rsp_data: got err=%0b rdata=%h, want err=%0b rdata=%h",
                   rsp_err, rsp_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [AW-1:0] addr, input logic [31:0] wdata);
    op_valid = 1'b1; op_we = we; op_size = size; op_unsigned = uns;
    op_addr = addr; op_wdata = wdata;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic bus_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [AW-1:0] addr, input logic [31:0] wdata,
                        input int gnt_wait, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rdata);
    logic [AW-1:0] exp_addr;
    exp_addr = {addr[AW-1:2], 2'b00};
    total++;
    if (op_ready !== 1'b1) begin
      bad++; $display("FAIL op_ready_pre: got %b want 1", op_ready);
    end
    sb.push_back({1'b0, exp_rdata});
    issue(we, size, uns, addr, wdata);
    for (int i = 0; i <= gnt_wait; i++) begin
      total++;
      if ({data_req, busy, data_addr, data_we, data_be, data_wdata} !==
          {2'b11, exp_addr, we, exp_be, exp_wd}) begin
        bad++;
        $display("FAIL req_fields(c%0d): got req=%b busy=%b addr=%h we=%b be=%b wd=%h want req=1 busy=1 addr=%h we=%b be=%b wd=%h",
                 i, data_req, busy, data_addr, data_we, data_be, data_wdata,
                 exp_addr, we, exp_be, exp_wd);
      end
      if (i == gnt_wait) data_gnt = 1'b1;
      tick();
    end
    data_gnt = 1'b0;
    total++;
    if ({data_req, busy, rsp_valid} !== 3'b010) begin
      bad++; $display("FAIL wait_state: got req=%b busy=%b rsp=%b want 0 1 0", data_req, busy, rsp_valid);
    end
    data_rvalid = 1'b1; data_rdata = rdata;
    tick();
    data_rvalid = 1'b0; data_rdata = 32'h0;
    total++;
    if ({rsp_valid, busy, op_ready} !== 3'b101) begin
      bad++; $display("FAIL rsp_timing: got rsp=%b busy=%b ready=%b want 1 0 1", rsp_valid, busy, op_ready);
    end
  endtask

  task automatic err_op(input logic [1:0] size, input logic [AW-1:0] addr);
    sb.push_back({1'b1, 32'h0});
    issue(1'b0, size, 1'b0, addr, 32'h0);
    total++;
    if ({data_req, op_ready, rsp_valid} !== 3'b000) begin
      bad++; $display("FAIL err_c1: got req=%b ready=%b rsp=%b want 0 0 0", data_req, op_ready, rsp_valid);
    end
    tick();
    total++;
    if ({data_req, rsp_valid, op_ready} !== 3'b011) begin
      bad++; $display("FAIL err_c2: got req=%b rsp=%b ready=%b want 0 1 1", data_req, rsp_valid, op_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    op_valid = 0; op_we = 0; op_size = 0; op_unsigned = 0; op_addr = 0; op_wdata = 0;
    data_gnt = 0; data_rvalid = 0; data_rdata = 0;
    tick(); tick();
    total++;
    if ({op_ready, rsp_valid, rsp_err, rsp_rdata, busy, data_req, data_addr, data_we, data_be, data_wdata} !== '0) begin
      bad++; $display("FAIL reset_outputs: got ready=%b req=%b busy=%b be=%b want all 0", op_ready, data_req, busy, data_be);
    end
    rst = 1'b0;
    tick();
    total++;
    if (op_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", op_ready);
    end
  endtask

  task automatic test_store();
    bus_op(1'b1, 2'b00, 1'b0, 15'h0003, 32'h000000A5, 0, 32'hDEADBEEF, 4'b1000, 32'hA5A5A5A5, 32'h0);
    bus_op(1'b1, 2'b01, 1'b0, 15'h0102, 32'h0000BEEF, 0, 32'h0, 4'b1100, 32'hBEEFBEEF, 32'h0);
    bus_op(1'b1, 2'b10, 1'b0, 15'h7FFC, 32'h12345678, 0, 32'h0, 4'b1111, 32'h12345678, 32'h0);
  endtask

  task automatic test_load();
    bus_op(1'b0, 2'b01, 1'b0, 15'h0006, 32'h0, 0, 32'h80011234, 4'b1100, 32'h0, 32'hFFFF8001);
    bus_op(1'b0, 2'b01, 1'b1, 15'h0006, 32'h0, 0, 32'h80011234, 4'b1100, 32'h0, 32'h00008001);
    bus_op(1'b0, 2'b00, 1'b0, 15'h0011, 32'h0, 0, 32'h00008000, 4'b0010, 32'h0, 32'hFFFFFF80);
    bus_op(1'b0, 2'b00, 1'b1, 15'h0011, 32'h0, 0, 32'h00008000, 4'b0010, 32'h0, 32'h00000080);
    bus_op(1'b0, 2'b10, 1'b0, 15'h0004, 32'h0, 0, 32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D);
  endtask

  task automatic test_misaligned();
    err_op(2'b10, 15'h0002);
    err_op(2'b01, 15'h0001);
    err_op(2'b11, 15'h0000);
  endtask

  task automatic test_contention();
    bus_op(1'b1, 2'b00, 1'b0, 15'h0021, 32'h0000003C, 5, 32'h0, 4'b0010, 32'h3C3C3C3C, 32'h0);
  endtask

  task automatic test_timeout();
    sb.push_back({1'b1, 32'h0});
    issue(1'b0, 2'b10, 1'b0, 15'h0008, 32'h0);
    data_gnt = 1'b1;
    tick();
    data_gnt = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      total++;
      if ({rsp_valid, busy} !== 2'b01) begin
        bad++; $display("FAIL timeout_wait(c%0d): got rsp=%b busy=%b want 0 1", i, rsp_valid, busy);
      end
      tick();
    end
    total++;
    if ({rsp_valid, busy, op_ready} !== 3'b101) begin
      bad++; $display("FAIL timeout_rsp: got rsp=%b busy=%b ready=%b want 1 0 1", rsp_valid, busy, op_ready);
    end
    tick();
    data_rvalid = 1'b1; data_rdata = 32'h55555555;
    tick();
    data_rvalid = 1'b0;
    total++;
    if ({rsp_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL late_rvalid: got rsp=%b busy=%b want 0 0", rsp_valid, busy);
    end
    bus_op(1'b0, 2'b10, 1'b0, 15'h000C, 32'h0, 0, 32'h01020304, 4'b1111, 32'h0, 32'h01020304);
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 2'b10, 1'b0, 15'h0010, 32'h0);
    data_gnt = 1'b1;
    tick();
    data_gnt = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({op_ready, rsp_valid, busy, data_req, data_be, data_wdata, data_addr} !== '0) begin
      bad++; $display("FAIL reset_mid: got ready=%b busy=%b req=%b be=%b want all 0", op_ready, busy, data_req, data_be);
    end
    tick();
    rst = 1'b0;
    data_rvalid = 1'b1; data_rdata = 32'hAAAAAAAA;
    tick();
    data_rvalid = 1'b0;
    total++;
    if ({rsp_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL post_reset_rvalid: got rsp=%b busy=%b want 0 0", rsp_valid, busy);
    end
    tick();
    total++;
    if (op_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset_ready: got %b want 1", op_ready);
    end
  endtask

  task automatic test_back_to_back();
    bus_op(1'b1, 2'b10, 1'b0, 15'h0040, 32'hA1B2C3D4, 0, 32'h0, 4'b1111, 32'hA1B2C3D4, 32'h0);
    bus_op(1'b0, 2'b00, 1'b0, 15'h0043, 32'h0, 0, 32'h7F000000, 4'b1000, 32'h0, 32'h0000007F);
    bus_op(1'b0, 2'b01, 1'b0, 15'h0040, 32'h0, 1, 32'h00007FFF, 4'b0011, 32'h0, 32'h00007FFF);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    tick(); tick();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
